// File: rtl/v_idx_mask_gen.sv
// Expands an element index + found flag into a stream of packed vmsof/vmsbf/vmsif mask chunks.
// Optional build macro: VL_TAIL_MASK_EN zeroes every mask bit whose element is at or beyond vl.
module v_idx_mask_gen #(
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned DATA_WIDTH_BITS = 6,
    parameter int unsigned IDX_BITS        = 10,
    parameter int unsigned REQ_ADDR_WIDTH  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [IDX_BITS+DATA_WIDTH_BITS-1:0]   in_idx,
    input  logic                                  in_found,
    input  logic [1:0]                            in_mode,
    input  logic [IDX_BITS+DATA_WIDTH_BITS:0]     in_vl,
    input  logic [REQ_ADDR_WIDTH-1:0]             in_addr,
    output logic [RESP_DATA_WIDTH-1:0]            out_vec,
    output logic [REQ_ADDR_WIDTH-1:0]             out_addr,
    output logic                                  out_end,
    output logic                                  out_valid,
    input  logic                                  out_ready
);
    localparam int unsigned EB = IDX_BITS + DATA_WIDTH_BITS;
    localparam int unsigned CW = IDX_BITS + 1;

    typedef enum logic {IDLE, GEN} state_e;

    state_e                      state_q;
    logic [EB-1:0]               idx_q;
    logic                        found_q;
    logic [1:0]                  mode_q;
    logic [REQ_ADDR_WIDTH-1:0]   base_q;
    logic [CW-1:0]               chunk_q;
    logic [CW-1:0]               last_q;
    logic [RESP_DATA_WIDTH-1:0]  vec_q;
    logic [REQ_ADDR_WIDTH-1:0]   addr_q;
    logic                        end_q;
    logic                        valid_q;
`ifdef VL_TAIL_MASK_EN
    logic [EB:0]                 vl_q;
    logic [EB:0]                 s_vl_c;
`endif

    logic                        sel_idle_c;
    logic [EB:0]                 s_idx_c;
    logic                        s_found_c;
    logic [1:0]                  s_mode_c;
    logic [CW-1:0]               s_chunk_c;
    logic [CW-1:0]               last_c;
    logic [RESP_DATA_WIDTH-1:0]  gen_vec_c;
    logic [REQ_ADDR_WIDTH-1:0]   gen_addr_c;

    assign in_ready  = (state_q == IDLE);
    assign out_vec   = vec_q;
    assign out_addr  = addr_q;
    assign out_end   = end_q;
    assign out_valid = valid_q;

    // Chunk 0 is built straight from the command inputs; later chunks from the latched copy.
    always_comb begin
        sel_idle_c = (state_q == IDLE);
        s_idx_c    = sel_idle_c ? {1'b0, in_idx} : {1'b0, idx_q};
        s_found_c  = sel_idle_c ? in_found : found_q;
        s_mode_c   = sel_idle_c ? in_mode  : mode_q;
        s_chunk_c  = sel_idle_c ? '0 : chunk_q;
`ifdef VL_TAIL_MASK_EN
        s_vl_c     = sel_idle_c ? in_vl : vl_q;
`endif
        last_c     = CW'((in_vl - (EB+1)'(1)) >> DATA_WIDTH_BITS);
        gen_addr_c = sel_idle_c ? in_addr : base_q + REQ_ADDR_WIDTH'(chunk_q);
    end

    // Per-bit element compare in EB+1-bit unsigned arithmetic.
    always_comb begin
        logic [EB:0] e;
        logic        b;
        gen_vec_c = '0;
        for (int j = 0; j < RESP_DATA_WIDTH; j++) begin
            e = {s_chunk_c, DATA_WIDTH_BITS'(j)};
            b = 1'b0;
            if (!s_found_c) begin
                b = (s_mode_c == 2'd1) || (s_mode_c == 2'd2);
            end else begin
                case (s_mode_c)
                    2'd1:    b = (e <  s_idx_c);
                    2'd2:    b = (e <= s_idx_c);
                    default: b = (e == s_idx_c);
                endcase
            end
`ifdef VL_TAIL_MASK_EN
            if (e >= s_vl_c) b = 1'b0;
`endif
            gen_vec_c[j] = b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            found_q <= 1'b0;
            mode_q  <= '0;
            base_q  <= '0;
            chunk_q <= '0;
            last_q  <= '0;
            vec_q   <= '0;
            addr_q  <= '0;
            end_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef VL_TAIL_MASK_EN
            vl_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    // A zero-length command is accepted and silently dropped.
                    if (in_valid && (in_vl != '0)) begin
                        idx_q   <= in_idx;
                        found_q <= in_found;
                        mode_q  <= in_mode;
                        base_q  <= in_addr;
                        last_q  <= last_c;
                        chunk_q <= CW'(1);
                        vec_q   <= gen_vec_c;
                        addr_q  <= gen_addr_c;
                        end_q   <= (last_c == '0);
                        valid_q <= 1'b1;
`ifdef VL_TAIL_MASK_EN
                        vl_q    <= in_vl;
`endif
                        state_q <= GEN;
                    end
                end
                GEN: begin
                    if (out_ready) begin
                        if (end_q) begin
                            valid_q <= 1'b0;
                            end_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            vec_q   <= gen_vec_c;
                            addr_q  <= gen_addr_c;
                            end_q   <= (chunk_q == last_q);
                            chunk_q <= chunk_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v_idx_mask_gen.sv
// Scoreboard bench for v_idx_mask_gen: directed commands push expected beats, a monitor pops them.
module tb_v_idx_mask_gen;
    localparam int unsigned RW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned EB = 16;
    localparam logic [RW-1:0] ONES = {RW{1'b1}};

    typedef struct {
        logic [RW-1:0] vec;
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [EB-1:0] in_idx;
    logic          in_found;
    logic [1:0]    in_mode;
    logic [EB:0]   in_vl;
    logic [AW-1:0] in_addr;
    logic [RW-1:0] out_vec;
    logic [AW-1:0] out_addr;
    logic          out_end;
    logic          out_valid;
    logic          out_ready;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    v_idx_mask_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_found  (in_found),
        .in_mode   (in_mode),
        .in_vl     (in_vl),
        .in_addr   (in_addr),
        .out_vec   (out_vec),
        .out_addr  (out_addr),
        .out_end   (out_end),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [RW-1:0] vec, input logic [AW-1:0] addr, input logic last);
        exp_t e;
        e.vec  = vec;
        e.addr = addr;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Drives one command, waits for acceptance, then checks the first-cycle response.
    task automatic send(input logic [EB-1:0] idx, input logic found, input logic [1:0] mode,
                        input logic [EB:0] vl, input logic [AW-1:0] addr);
        int n = 0;
        while (!in_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL idle_wait actual=busy required=idle");
        end
        in_idx = idx; in_found = found; in_mode = mode; in_vl = vl; in_addr = addr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (vl != '0) begin
            chk("first_beat_valid", RW'(out_valid), RW'(1));
            chk("busy_in_ready", RW'(in_ready), RW'(0));
        end else begin
            chk("drop_valid", RW'(out_valid), RW'(0));
            chk("drop_in_ready", RW'(in_ready), RW'(1));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", RW'(exp_q.size()), RW'(0));
    endtask

    // Monitor: a beat presented with out_ready high is consumed at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat actual=vec 0x%0h addr 0x%0h required=no beat", out_vec, out_addr);
            end else begin
                e = exp_q.pop_front();
                chk("beat_vec", out_vec, e.vec);
                chk("beat_addr", RW'(out_addr), RW'(e.addr));
                chk("beat_end", RW'(out_end), RW'(e.last));
                chk("gen_in_ready", RW'(in_ready), RW'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] h_vec;
        logic [AW-1:0] h_addr;
        logic          h_end;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_idx = '0; in_found = 1'b0; in_mode = '0; in_vl = '0; in_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", RW'(out_valid), RW'(0));
        chk("rst_vec", out_vec, RW'(0));
        chk("rst_addr", RW'(out_addr), RW'(0));
        chk("rst_end", RW'(out_end), RW'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", RW'(in_ready), RW'(1));

        // Single-beat onehot
        push(64'h20, 32'h100, 1'b1);
        send(16'd5, 1'b1, 2'd0, 17'd64, 32'h100);
        drain();

        // BEFORE across four chunks
        push(ONES, 32'h1000, 1'b0);
        push(64'h3F, 32'h1001, 1'b0);
        push(64'h0, 32'h1002, 1'b0);
        push(64'h0, 32'h1003, 1'b1);
        send(16'd70, 1'b1, 2'd1, 17'd200, 32'h1000);
        drain();

        // Not found: INCLUDING all ones, ONEHOT all zeros
        push(ONES, 32'h40, 1'b0);
        push(ONES, 32'h41, 1'b1);
        send(16'd5, 1'b0, 2'd2, 17'd128, 32'h40);
        drain();
        push(64'h0, 32'h80, 1'b0);
        push(64'h0, 32'h81, 1'b1);
        send(16'd5, 1'b0, 2'd0, 17'd128, 32'h80);
        drain();

        // INCLUDING with a three-cycle stall on beat 0
        out_ready = 1'b0;
        push(ONES, 32'h2000, 1'b0);
        push(ONES, 32'h2001, 1'b0);
        push(64'h3, 32'h2002, 1'b1);
        send(16'd129, 1'b1, 2'd2, 17'd130, 32'h2000);
        h_vec = out_vec; h_addr = out_addr; h_end = out_end;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", RW'(out_valid), RW'(1));
            chk("stall_vec", out_vec, h_vec);
            chk("stall_addr", RW'(out_addr), RW'(h_addr));
            chk("stall_end", RW'(out_end), RW'(h_end));
        end
        out_ready = 1'b1;
        drain();

        // vl=0 dropped, followed back-to-back by a real command
        push(64'h1, 32'h300, 1'b1);
        send(16'd0, 1'b0, 2'd0, 17'd0, 32'h200);
        send(16'd0, 1'b1, 2'd0, 17'd64, 32'h300);
        drain();

        // Reset while beat 2 of 4 is presented
        push(ONES, 32'h400, 1'b0);
        push(64'hF_FFFF_FFFF, 32'h401, 1'b0);
        send(16'd100, 1'b1, 2'd1, 17'd256, 32'h400);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("mid_beat2_valid", RW'(out_valid), RW'(1));
        chk("mid_beat2_vec", out_vec, RW'(0));
        chk("mid_beat2_addr", RW'(out_addr), RW'(32'h402));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", RW'(out_valid), RW'(0));
        chk("mid_rst_in_ready", RW'(in_ready), RW'(1));
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_valid", RW'(out_valid), RW'(0));
        chk("post_rst_queue", RW'(exp_q.size()), RW'(0));

        // Tail bits past vl
        push(ONES, 32'h500, 1'b0);
`ifdef VL_TAIL_MASK_EN
        push(64'h3F, 32'h501, 1'b1);
`else
        push(ONES, 32'h501, 1'b1);
`endif
        send(16'd3, 1'b0, 2'd1, 17'd70, 32'h500);
        drain();

        // Mode 3 behaves as ONEHOT; address wraps
        push(64'h0, 32'hFFFF_FFFE, 1'b0);
        push(64'h0, 32'hFFFF_FFFF, 1'b0);
        push(64'h4, 32'h0, 1'b1);
        send(16'd130, 1'b1, 2'd3, 17'd192, 32'hFFFF_FFFE);
        drain();

        // idx beyond vl
        push(ONES, 32'h600, 1'b1);
        send(16'd100, 1'b1, 2'd2, 17'd64, 32'h600);
        drain();

        // Maximum vl: 1024 chunks, onehot on the very last element
        for (int i = 0; i < 1024; i++) begin
            push((i == 1023) ? 64'h8000_0000_0000_0000 : 64'h0, 32'(i), (i == 1023));
        end
        send(16'hFFFF, 1'b1, 2'd0, 17'h1_0000, 32'h0);
        drain();

        chk("final_queue", RW'(exp_q.size()), RW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
